// File: rtl/lzw_pkg.sv
// Shared definitions for the LZW encoder: block state encoding, default code
// geometry and the code-width helper used by the packer and dictionary controller.
package lzw_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FLUSH  = 2'd1,
        DONE   = 2'd2
    } lzw_state_e;

    localparam int LZW_MIN_BITS   = 9;
    localparam int LZW_MAX_BITS   = 13;
    localparam int LZW_FIRST_CODE = 256;

    // Width needed for the code about to be assigned, clamped to [min_bits, max_bits].
    function automatic logic [4:0] width_for_code(input logic [16:0] next_code,
                                                  input logic [4:0]  min_bits,
                                                  input logic [4:0]  max_bits);
        logic [4:0] need;
        need = 5'd0;
        for (int i = 0; i < 17; i++) begin
            need = next_code[i] ? 5'(i + 1) : need;
        end
        width_for_code = (need < min_bits) ? min_bits :
                         ((need > max_bits) ? max_bits : need);
    endfunction

endpackage

// File: rtl/lzw_bitbuf.sv
// LSB-first bit accumulator: ORs a masked code in above the held bits, or
// pops the low byte out. Holds at most MAX_BITS+7 bits.
module lzw_bitbuf
    import lzw_pkg::*;
#(
    parameter int  MAX_BITS = LZW_MAX_BITS,
    localparam int BW       = MAX_BITS + 7,
    localparam int CW       = $clog2(MAX_BITS + 8)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                load,
    input  logic [MAX_BITS-1:0] load_code,
    input  logic [4:0]          load_width,
    input  logic                pop8,
    output logic [7:0]          low_byte,
    output logic [CW-1:0]       bit_cnt
);

    localparam logic [CW-1:0] BYTE_BITS = CW'(4'd8);

    logic [BW-1:0] bits_r;
    logic [BW-1:0] mask_s;
    logic [BW-1:0] ins_s;
    logic [CW-1:0] cnt_r;

    // Keep only the active code bits and align them just above the held bits.
    always_comb begin
        mask_s = ~({BW{1'b1}} << load_width);
        ins_s  = (BW'(load_code) & mask_s) << cnt_r;
    end

    // Buffer contents and fill level; a pop below one byte empties the buffer (pad byte).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_r <= '0;
            cnt_r  <= '0;
        end else if (clr) begin
            bits_r <= '0;
            cnt_r  <= '0;
        end else if (load) begin
            bits_r <= bits_r | ins_s;
            cnt_r  <= cnt_r + CW'(load_width);
        end else if (pop8) begin
            bits_r <= bits_r >> 4'd8;
            cnt_r  <= (cnt_r >= BYTE_BITS) ? (cnt_r - BYTE_BITS) : '0;
        end else begin
            bits_r <= bits_r;
            cnt_r  <= cnt_r;
        end
    end

    assign low_byte = bits_r[7:0];
    assign bit_cnt  = cnt_r;

endmodule

// File: rtl/lzw_code_packer.sv
// LZW output stage: packs variable-width dictionary codes LSB-first into bytes
// and writes them to port B of the output RAM, reporting the byte count.
module lzw_code_packer
    import lzw_pkg::*;
#(
    parameter int  MIN_BITS   = LZW_MIN_BITS,
    parameter int  MAX_BITS   = LZW_MAX_BITS,
    parameter int  FIRST_CODE = LZW_FIRST_CODE,
    parameter int  DEPTH      = 4096,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init,
    input  logic                code_valid,
    input  logic [MAX_BITS-1:0] code,
    output logic                code_ready,
    input  logic                flush,
    output logic                wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [7:0]          wr_byte,
    output logic [AW:0]         byte_cnt,
    output logic [3:0]          cur_width,
    output logic                done,
    output logic                ovf
);

    localparam int CW = $clog2(MAX_BITS + 8);

    localparam logic [1:0]        ST_ACTIVE  = 2'(ACTIVE);
    localparam logic [1:0]        ST_FLUSH   = 2'(FLUSH);
    localparam logic [1:0]        ST_DONE    = 2'(DONE);
    localparam logic [MAX_BITS:0] ONE_CODE   = (MAX_BITS + 1)'(1'b1);
    localparam logic [MAX_BITS:0] SAT_CODE   = ONE_CODE << MAX_BITS;
    localparam logic [MAX_BITS:0] FIRST_NC   = (MAX_BITS + 1)'(FIRST_CODE);
    localparam logic [AW:0]       FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [4:0]        MIN_W      = 5'(MIN_BITS);
    localparam logic [4:0]        MAX_W      = 5'(MAX_BITS);
    localparam logic [CW-1:0]     BYTE_BITS  = CW'(4'd8);

    logic [1:0]        state_r;
    logic [4:0]        width_r;
    logic [MAX_BITS:0] next_code_r;
    logic [AW:0]       byte_cnt_r;
    logic [AW-1:0]     wr_addr_r;
    logic [7:0]        wr_byte_r;
    logic              wr_en_r;
    logic              done_r;
    logic              ovf_r;
    logic              ready_r;

    logic [CW-1:0]     bit_cnt_s;
    logic [CW-1:0]     bit_cnt_nxt_s;
    logic [7:0]        low_byte_s;
    logic [1:0]        state_nxt_s;
    logic [MAX_BITS:0] next_code_inc_s;
    logic              has_byte_s;
    logic              accept_s;
    logic              emit_s;
    logic              pad_s;
    logic              pop_s;
    logic              full_s;
    logic              grow_s;
    logic              ready_nxt_s;

    lzw_bitbuf #(
        .MAX_BITS (MAX_BITS)
    ) u_bitbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (init),
        .load       (accept_s),
        .load_code  (code),
        .load_width (width_r),
        .pop8       (pop_s),
        .low_byte   (low_byte_s),
        .bit_cnt    (bit_cnt_s)
    );

    // Handshake, emit/pad decisions, width growth and the next-cycle view of the buffer.
    always_comb begin
        has_byte_s = (bit_cnt_s >= BYTE_BITS);
        accept_s   = code_valid & ready_r;
        emit_s     = has_byte_s & (state_r != ST_DONE);
        pad_s      = (state_r == ST_FLUSH) & ~has_byte_s & (bit_cnt_s != '0);
        pop_s      = emit_s | pad_s;
        full_s     = (byte_cnt_r == FULL_CNT);

        if (next_code_r == SAT_CODE) begin
            next_code_inc_s = next_code_r;
        end else begin
            next_code_inc_s = next_code_r + ONE_CODE;
        end
        grow_s = (next_code_inc_s == (ONE_CODE << width_r)) & (width_r < MAX_W);

        if (accept_s) begin
            bit_cnt_nxt_s = bit_cnt_s + CW'(width_r);
        end else if (pop_s) begin
            bit_cnt_nxt_s = has_byte_s ? (bit_cnt_s - BYTE_BITS) : '0;
        end else begin
            bit_cnt_nxt_s = bit_cnt_s;
        end

        case (state_r)
            ST_ACTIVE: state_nxt_s = flush ? ST_FLUSH : ST_ACTIVE;
            ST_FLUSH:  state_nxt_s = has_byte_s ? ST_FLUSH : ST_DONE;
            ST_DONE:   state_nxt_s = ST_ACTIVE;
            default:   state_nxt_s = ST_ACTIVE;
        endcase

        // code_ready is registered, so it is computed from next-cycle state and fill.
        ready_nxt_s = (state_nxt_s == ST_ACTIVE) & (bit_cnt_nxt_s < BYTE_BITS);
    end

    // Control state, dictionary width tracking, byte counter and the RAM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_ACTIVE;
            width_r     <= MIN_W;
            next_code_r <= FIRST_NC;
            byte_cnt_r  <= '0;
            wr_addr_r   <= '0;
            wr_byte_r   <= 8'd0;
            wr_en_r     <= 1'b0;
            done_r      <= 1'b0;
            ovf_r       <= 1'b0;
            ready_r     <= 1'b0;
        end else if (init) begin
            state_r     <= ST_ACTIVE;
            width_r     <= MIN_W;
            next_code_r <= FIRST_NC;
            byte_cnt_r  <= '0;
            wr_addr_r   <= '0;
            wr_byte_r   <= 8'd0;
            wr_en_r     <= 1'b0;
            done_r      <= 1'b0;
            ovf_r       <= 1'b0;
            ready_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= ready_nxt_s;
            done_r  <= (state_nxt_s == ST_DONE);
            wr_en_r <= pop_s & ~full_s;
            if (pop_s & ~full_s) begin
                wr_addr_r  <= byte_cnt_r[AW-1:0];
                wr_byte_r  <= low_byte_s;
                byte_cnt_r <= byte_cnt_r + (AW + 1)'(1'b1);
            end else begin
                wr_addr_r  <= wr_addr_r;
                wr_byte_r  <= wr_byte_r;
                byte_cnt_r <= byte_cnt_r;
            end
            // A full RAM still consumes buffer bits; the dropped byte is flagged.
            ovf_r <= ovf_r | (pop_s & full_s);
            if (accept_s) begin
                next_code_r <= next_code_inc_s;
                width_r     <= grow_s ? (width_r + 5'd1) : width_r;
            end else begin
                next_code_r <= next_code_r;
                width_r     <= width_r;
            end
        end
    end

    assign code_ready = ready_r;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_byte    = wr_byte_r;
    assign byte_cnt   = byte_cnt_r;
    assign cur_width  = width_r[3:0];
    assign done       = done_r;
    assign ovf        = ovf_r;

endmodule
